mc_control_fsm: RTL and testbench

//  Multicycle control unit: the other end of the datapath control interface. It latches the
//  32-bit instruction fetched by the datapath and sequences the datapath control inputs
//  (RegWrite, MemtoReg, ALUsrc, MemWrite, MemRead, ALU_CC) over several cycles.
//  It advances the PC via PC_en and waits on a data-memory ready handshake.

---
 rtl/mc_control_fsm_if.sv | 30 +++
 rtl/mc_control_fsm.sv | 256 +++++++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mc_control_fsm_if.sv
// Control interface between the multicycle control unit and the datapath.
// The master side is the control FSM and the slave side is the datapath.
interface mc_control_fsm_if #(
    parameter int INS_W    = 32,
    parameter int ALU_CC_W = 4
);
    logic [INS_W-1:0]    IM;
    logic                mem_ready;
    logic                RegWrite;
    logic                MemtoReg;
    logic                ALUsrc;
    logic                MemWrite;
    logic                MemRead;
    logic [ALU_CC_W-1:0] ALU_CC;
    logic                PC_en;
    logic                illegal_inst;
    logic                mem_err;

    modport master (
        input  IM, mem_ready,
        output RegWrite, MemtoReg, ALUsrc, MemWrite, MemRead, ALU_CC,
               PC_en, illegal_inst, mem_err
    );

    modport slave (
        output IM, mem_ready,
        input  RegWrite, MemtoReg, ALUsrc, MemWrite, MemRead, ALU_CC,
               PC_en, illegal_inst, mem_err
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle control unit: FETCH -> DECODE -> EXEC -> {MEM} -> WB -> FETCH.
// Latches the fetched instruction and sequences the datapath controls.
// Optional MC_PERF_CNT_EN adds cycle_cnt / instret_cnt performance counters.
module mc_control_fsm #(
    parameter int INS_W    = 32,
    parameter int ALU_CC_W = 4,
    parameter int TIMEOUT  = 15,
    parameter int PERF_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    mc_control_fsm_if.master   bus
`ifdef MC_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0]  cycle_cnt,
    output logic [PERF_W-1:0]  instret_cnt
`endif
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_SD = 7'b0100011;

    localparam logic [ALU_CC_W-1:0] CC_AND = ALU_CC_W'(4'b0000);
    localparam logic [ALU_CC_W-1:0] CC_OR  = ALU_CC_W'(4'b0001);
    localparam logic [ALU_CC_W-1:0] CC_ADD = ALU_CC_W'(4'b0010);
    localparam logic [ALU_CC_W-1:0] CC_SUB = ALU_CC_W'(4'b0110);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_ABORT
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [INS_W-1:0]    ir;
    logic [CNT_W-1:0]    wait_cnt;
    logic                illegal_q;
    logic                mem_err_q;

    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic                is_rtype;
    logic                is_itype;
    logic                is_ld;
    logic                is_sd;
    logic                legal;
    logic                alusrc_dec;
    logic [ALU_CC_W-1:0] alu_cc_dec;
    logic                mem_timeout;
    logic                sd_done;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];

    assign legal       = is_rtype | is_itype | is_ld | is_sd;
    assign alusrc_dec  = is_itype | is_ld | is_sd;
    assign mem_timeout = (wait_cnt == CNT_W'(TIMEOUT - 1)) && !bus.mem_ready;
    assign sd_done     = (state == S_MEM) && is_sd && bus.mem_ready;

    // Decode the latched instruction into its class and ALU operation.
    always_comb begin
        is_rtype   = 1'b0;
        is_itype   = 1'b0;
        is_ld      = 1'b0;
        is_sd      = 1'b0;
        alu_cc_dec = CC_ADD;
        case (opcode)
            OP_R: begin
                case (funct3)
                    3'b000: begin
                        if (funct7 == 7'b0000000) begin
                            is_rtype   = 1'b1;
                            alu_cc_dec = CC_ADD;
                        end else if (funct7 == 7'b0100000) begin
                            is_rtype   = 1'b1;
                            alu_cc_dec = CC_SUB;
                        end
                    end
                    3'b111: begin
                        if (funct7 == 7'b0000000) begin
                            is_rtype   = 1'b1;
                            alu_cc_dec = CC_AND;
                        end
                    end
                    3'b110: begin
                        if (funct7 == 7'b0000000) begin
                            is_rtype   = 1'b1;
                            alu_cc_dec = CC_OR;
                        end
                    end
                    default: ;
                endcase
            end
            OP_I: begin
                case (funct3)
                    3'b000: begin
                        is_itype   = 1'b1;
                        alu_cc_dec = CC_ADD;
                    end
                    3'b111: begin
                        is_itype   = 1'b1;
                        alu_cc_dec = CC_AND;
                    end
                    3'b110: begin
                        is_itype   = 1'b1;
                        alu_cc_dec = CC_OR;
                    end
                    default: ;
                endcase
            end
            OP_LD: is_ld = (funct3 == 3'b011);
            OP_SD: is_sd = (funct3 == 3'b011);
            default: ;
        endcase
    end

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Instruction register, loaded only while leaving FETCH so IM never reaches outputs directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir <= '0;
        end else if (state == S_FETCH) begin
            ir <= bus.IM;
        end
    end

    // Count MEM cycles; cleared whenever the FSM is elsewhere.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state != S_MEM) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            if ((state == S_DECODE) && !legal) begin
                illegal_q <= 1'b1;
            end
            if ((state == S_MEM) && mem_timeout) begin
                mem_err_q <= 1'b1;
            end
        end
    end

    // Next-state sequencing, including the memory wait and timeout abort.
    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: next_state = legal ? S_EXEC : S_FETCH;
            S_EXEC:   next_state = (is_ld || is_sd) ? S_MEM : S_WB;
            S_MEM: begin
                if (bus.mem_ready) begin
                    next_state = is_ld ? S_WB : S_FETCH;
                end else if (mem_timeout) begin
                    next_state = S_ABORT;
                end else begin
                    next_state = S_MEM;
                end
            end
            S_WB:     next_state = S_FETCH;
            S_ABORT:  next_state = S_FETCH;
            default:  next_state = S_FETCH;
        endcase
    end

    // Datapath controls from state and IR; a store retires in MEM on the ready cycle itself.
    always_comb begin
        bus.RegWrite = 1'b0;
        bus.MemtoReg = 1'b0;
        bus.ALUsrc   = 1'b0;
        bus.MemWrite = 1'b0;
        bus.MemRead  = 1'b0;
        bus.ALU_CC   = '0;
        bus.PC_en    = 1'b0;
        case (state)
            S_DECODE: begin
                bus.PC_en = !legal;
            end
            S_EXEC: begin
                bus.ALU_CC = alu_cc_dec;
                bus.ALUsrc = alusrc_dec;
            end
            S_MEM: begin
                bus.ALU_CC   = alu_cc_dec;
                bus.ALUsrc   = alusrc_dec;
                bus.MemRead  = is_ld;
                bus.MemWrite = is_sd;
                bus.PC_en    = is_sd && bus.mem_ready;
            end
            S_WB: begin
                bus.ALU_CC   = alu_cc_dec;
                bus.ALUsrc   = alusrc_dec;
                bus.RegWrite = 1'b1;
                bus.MemtoReg = is_ld;
                bus.MemRead  = is_ld;
                bus.PC_en    = 1'b1;
            end
            S_ABORT: begin
                bus.PC_en = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.illegal_inst = illegal_q;
    assign bus.mem_err      = mem_err_q;

`ifdef MC_PERF_CNT_EN
    // Free-running cycle counter and retired-instruction counter (illegal and aborted excluded).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + PERF_W'(1);
            if ((state == S_WB) || sd_done) begin
                instret_cnt <= instret_cnt + PERF_W'(1);
            end
        end
    end
`else
    // Store-retire indication only feeds the performance counters.
    always_comb begin
        if (sd_done) begin
        end
    end
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed scoreboard bench for mc_control_fsm.
// Expected per-cycle control vectors are built from instruction class and wait count.
module tb_mc_control_fsm;

    localparam int          TIMEOUT = 15;
    localparam int          K_R     = 0;
    localparam int          K_LD    = 1;
    localparam int          K_SD    = 2;
    localparam int          K_ILL   = 3;
    localparam logic [31:0] JUNK    = 32'hFFFF_FFFF;
    localparam logic [3:0]  CC_AND  = 4'b0000;
    localparam logic [3:0]  CC_OR   = 4'b0001;
    localparam logic [3:0]  CC_ADD  = 4'b0010;
    localparam logic [3:0]  CC_SUB  = 4'b0110;

    logic        clk = 1'b0;
    logic        reset;
    int          vectors = 0;
    int          miscompares = 0;
    logic        exp_ill = 1'b0;
    logic        exp_merr = 1'b0;
    logic [12:0] exp_q[$];
    string       tag_q[$];
    logic [12:0] obs;

`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;
`endif

    mc_control_fsm_if bus ();

    mc_control_fsm #(.TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.master)
`ifdef MC_PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
`endif
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    assign obs = {bus.RegWrite, bus.MemtoReg, bus.ALUsrc, bus.MemWrite, bus.MemRead,
                  bus.ALU_CC, bus.PC_en, bus.illegal_inst, bus.mem_err};

    function automatic logic [12:0] mk(input logic rw, input logic mtr, input logic src,
                                       input logic mw, input logic mr, input logic [3:0] cc,
                                       input logic pc);
        return {rw, mtr, src, mw, mr, cc, pc, exp_ill, exp_merr};
    endfunction

    task automatic check_output();
        logic [12:0] e;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        vectors++;
        assert (obs === e) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %b expected %b", t, obs, e);
        end
    endtask

    task automatic expect_now(input string tag, input logic [12:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        check_output();
    endtask

    task automatic apply_stimulus(input string tag, input logic [31:0] im_v, input logic rdy,
                                  input logic [12:0] e);
        bus.IM        = im_v;
        bus.mem_ready = rdy;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #2;
        check_output();
        @(negedge clk);
    endtask

    task automatic run_instr(input string tag, input logic [31:0] ins, input int kind,
                             input logic [3:0] cc, input logic src, input int waits,
                             input logic idle_rdy);
        logic rdy;
        apply_stimulus({tag, "/fetch"}, ins, idle_rdy, mk(0, 0, 0, 0, 0, 4'b0000, 0));
        if (kind == K_ILL) begin
            apply_stimulus({tag, "/decode"}, JUNK, idle_rdy, mk(0, 0, 0, 0, 0, 4'b0000, 1));
            exp_ill = 1'b1;
            return;
        end
        apply_stimulus({tag, "/decode"}, JUNK, idle_rdy, mk(0, 0, 0, 0, 0, 4'b0000, 0));
        apply_stimulus({tag, "/exec"}, JUNK, idle_rdy, mk(0, 0, src, 0, 0, cc, 0));
        if (kind == K_R) begin
            apply_stimulus({tag, "/wb"}, JUNK, idle_rdy, mk(1, 0, src, 0, 0, cc, 1));
            return;
        end
        for (int k = 0; k < TIMEOUT; k++) begin
            rdy = (k == waits);
            if (rdy) begin
                if (kind == K_LD) begin
                    apply_stimulus({tag, "/mem"}, JUNK, 1'b1, mk(0, 0, src, 0, 1, cc, 0));
                    apply_stimulus({tag, "/wb"}, JUNK, idle_rdy, mk(1, 1, src, 0, 1, cc, 1));
                end else begin
                    apply_stimulus({tag, "/mem"}, JUNK, 1'b1, mk(0, 0, src, 1, 0, cc, 1));
                end
                return;
            end
            apply_stimulus({tag, "/mem_wait"}, JUNK, 1'b0,
                           mk(0, 0, src, kind == K_SD, kind == K_LD, cc, 0));
        end
        exp_merr = 1'b1;
        apply_stimulus({tag, "/abort"}, JUNK, idle_rdy, mk(0, 0, 0, 0, 0, 4'b0000, 1));
    endtask

    // Directed sequence of instructions with reset in the middle of a store.
    initial begin
        reset         = 1'b1;
        bus.IM        = 32'h0;
        bus.mem_ready = 1'b0;
        #2;
        expect_now("reset_state", mk(0, 0, 0, 0, 0, 4'b0000, 0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

`ifdef MC_PERF_CNT_EN
        for (int n = 0; n < 3; n++) begin
            run_instr("perf_add", 32'h002081B3, K_R, CC_ADD, 1'b0, 0, 1'b1);
        end
        vectors++;
        assert (cycle_cnt === 32'd12) else begin
            miscompares++;
            $error("[TB] FAIL cycle_cnt: observed %0d expected 12", cycle_cnt);
        end
        vectors++;
        assert (instret_cnt === 32'd3) else begin
            miscompares++;
            $error("[TB] FAIL instret_cnt: observed %0d expected 3", instret_cnt);
        end
`endif

        run_instr("add",  32'h002081B3, K_R,  CC_ADD, 1'b0, 0, 1'b1);
        run_instr("sub",  32'h402081B3, K_R,  CC_SUB, 1'b0, 0, 1'b0);
        run_instr("ori",  32'h0040E193, K_R,  CC_OR,  1'b1, 0, 1'b0);
        run_instr("and",  32'h0020F1B3, K_R,  CC_AND, 1'b0, 0, 1'b1);
        run_instr("or",   32'h0020E1B3, K_R,  CC_OR,  1'b0, 0, 1'b0);
        run_instr("addi", 32'h00508193, K_R,  CC_ADD, 1'b1, 0, 1'b0);
        run_instr("andi", 32'h0050F193, K_R,  CC_AND, 1'b1, 0, 1'b1);
        run_instr("ld_w2", 32'h00803283, K_LD, CC_ADD, 1'b1, 2, 1'b0);
        run_instr("ld_w0", 32'h00803283, K_LD, CC_ADD, 1'b1, 0, 1'b1);
        run_instr("sd_w0", 32'h00503823, K_SD, CC_ADD, 1'b1, 0, 1'b0);
        run_instr("sd_w3", 32'h00503823, K_SD, CC_ADD, 1'b1, 3, 1'b1);
        run_instr("ill_ones", 32'hFFFFFFFF, K_ILL, CC_AND, 1'b0, 0, 1'b0);
        run_instr("ill_mul",  32'h022081B3, K_ILL, CC_AND, 1'b0, 0, 1'b1);
        run_instr("ill_lw",   32'h00802283, K_ILL, CC_AND, 1'b0, 0, 1'b0);
        run_instr("add_after_ill", 32'h002081B3, K_R, CC_ADD, 1'b0, 0, 1'b0);
        run_instr("ld_timeout", 32'h00803283, K_LD, CC_ADD, 1'b1, -1, 1'b0);
        run_instr("sd_timeout", 32'h00503823, K_SD, CC_ADD, 1'b1, -1, 1'b1);
        run_instr("sd_after_err", 32'h00503823, K_SD, CC_ADD, 1'b1, 1, 1'b0);

        apply_stimulus("sd_rst/fetch",  32'h00503823, 1'b0, mk(0, 0, 0, 0, 0, 4'b0000, 0));
        apply_stimulus("sd_rst/decode", JUNK, 1'b0, mk(0, 0, 0, 0, 0, 4'b0000, 0));
        apply_stimulus("sd_rst/exec",   JUNK, 1'b0, mk(0, 0, 1, 0, 0, CC_ADD, 0));
        apply_stimulus("sd_rst/mem",    JUNK, 1'b0, mk(0, 0, 1, 1, 0, CC_ADD, 0));
        reset         = 1'b1;
        bus.mem_ready = 1'b1;
        #1;
        exp_ill  = 1'b0;
        exp_merr = 1'b0;
        expect_now("sd_rst/async_drop", mk(0, 0, 0, 0, 0, 4'b0000, 0));
        @(negedge clk);
        reset = 1'b0;
        run_instr("add_after_rst", 32'h002081B3, K_R, CC_ADD, 1'b0, 0, 1'b1);
        run_instr("ld_after_rst",  32'h00803283, K_LD, CC_ADD, 1'b1, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
